// File: rtl/cordic_ctrl_pkg.sv
// Shared types and per-mode tables for the CORDIC command dispatcher.
package cordic_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdSample, StDecode, StStart, StWaitDone, StWr, StErr
  } state_e;

  localparam int unsigned MODE_LSB    = 8;
  localparam int unsigned PAYLOAD_LSB = 16;

  localparam logic [15:0] TAG_ERR_MISMATCH = 16'h00ED;
  localparam logic [15:0] TAG_ERR_MODE     = 16'h00EE;
  localparam logic [15:0] TAG_ERR_TIMEOUT  = 16'h00EF;

  function automatic logic [1:0] mode_nops(input logic [7:0] mode);
    return (mode == 8'd8) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] mode_nres(input logic [7:0] mode);
    case (mode)
      8'd1, 8'd2, 8'd4: return 2'd2;
      8'd3:             return 2'd3;
      default:          return 2'd1;
    endcase
  endfunction

  function automatic logic [15:0] mode_tag(input logic [7:0] mode, input logic [1:0] slot);
    case (mode)
      8'd1, 8'd2, 8'd4: return (slot == 2'd0) ? 16'h000A : 16'h000C;
      8'd3: begin
        case (slot)
          2'd0:    return 16'h000A;
          2'd1:    return 16'h000C;
          default: return 16'h000B;
        endcase
      end
      8'd5:    return 16'h000E;
      8'd6:    return 16'h000F;
      8'd7:    return 16'h000D;
      default: return 16'h000B;
    endcase
  endfunction

endpackage

// File: rtl/cordic_res_serializer.sv
// Holds up to three tagged result words and drains them one per non-full cycle.
module cordic_res_serializer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [1:0]            nres,
  input  logic [3*DATA_W-1:0]   res,
  input  logic [47:0]           tags,
  input  logic                  out_full,
  output logic                  wr_en,
  output logic [DATA_W+15:0]    data,
  output logic                  done
);

  logic [DATA_W+15:0] words_q [3];
  logic [1:0]         slot_q;
  logic [1:0]         last_q;
  logic               active_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) words_q[k] <= '0;
      slot_q   <= '0;
      last_q   <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      for (int k = 0; k < 3; k++) words_q[k] <= {tags[k*16 +: 16], res[k*DATA_W +: DATA_W]};
      slot_q   <= '0;
      last_q   <= nres - 2'd1;
      active_q <= 1'b1;
    end else if (wr_en) begin
      if (done) active_q <= 1'b0;
      else      slot_q   <= slot_q + 2'd1;
    end
  end

  always_comb begin
    wr_en = active_q && !out_full;
    done  = wr_en && (slot_q == last_q);
    case (slot_q)
      2'd0:    data = words_q[0];
      2'd1:    data = words_q[1];
      default: data = words_q[2];
    endcase
  end

endmodule

// File: rtl/cordic_dispatch_ctrl.sv
// Pops commands, gathers operands, starts one CORDIC engine and pushes tagged results.
module cordic_dispatch_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_ENG   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_W+15:0]        in_data,
  input  logic                      in_empty,
  output logic                      in_rd_en,
  input  logic                      out_full,
  output logic                      out_wr_en,
  output logic [DATA_W+15:0]        out_data,
  output logic [N_ENG-1:0]          eng_start,
  output logic [DATA_W-1:0]         eng_a,
  output logic [DATA_W-1:0]         eng_b,
  input  logic [N_ENG-1:0]          eng_done,
  input  logic [N_ENG*3*DATA_W-1:0] eng_res,
  output logic                      busy,
  output logic [7:0]                err_cnt
);

  localparam int unsigned WORD_W = DATA_W + 16;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   cmd_q;
  logic [7:0]          mode_q;
  logic                have_a_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [TMR_W-1:0]    timer_q;
  logic [15:0]         err_tag_q;
  logic [7:0]          err_mode_q;
  logic [7:0]          err_cnt_q;

  logic [7:0]          cmd_mode;
  logic [DATA_W-1:0]   cmd_payload;
  logic                mode_bad;
  logic [2:0]          eng_idx;
  logic [N_ENG-1:0]    eng_sel;
  logic                eng_hit;
  logic                timed_out;
  logic [3*DATA_W-1:0] res_sel;
  logic                ser_wr_en, ser_done;
  logic [WORD_W-1:0]   ser_data;
  logic                unused_cmd;

  assign cmd_mode    = cmd_q[MODE_LSB +: 8];
  assign cmd_payload = cmd_q[PAYLOAD_LSB +: DATA_W];
  assign unused_cmd  = ^cmd_q[MODE_LSB-1:0];
  assign mode_bad    = (cmd_mode == 8'd0) || ({24'd0, cmd_mode} > N_ENG);
  assign eng_idx     = 3'(mode_q - 8'd1);
  assign eng_sel     = N_ENG'(1) << eng_idx;
  // Only the engine we started counts; stray done pulses are dropped.
  assign eng_hit     = |(eng_done & eng_sel);
  assign timed_out   = !eng_hit && (timer_q == TMR_LAST);

  always_comb begin
    res_sel = '0;
    for (int e = 0; e < N_ENG; e++) begin
      if (eng_idx == 3'(e)) res_sel = eng_res[e*3*DATA_W +: 3*DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!in_empty) state_d = StRdReq;
      StRdReq:    if (!in_empty) state_d = StRdSample;
      StRdSample: state_d = StDecode;
      StDecode: begin
        if (have_a_q)                      state_d = (cmd_mode == mode_q) ? StStart : StErr;
        else if (mode_bad)                 state_d = StErr;
        else if (mode_nops(cmd_mode) == 2) state_d = StRdReq;
        else                               state_d = StStart;
      end
      StStart:    state_d = StWaitDone;
      StWaitDone: begin
        if (eng_hit)        state_d = StWr;
        else if (timed_out) state_d = StErr;
      end
      StWr:       if (ser_done) state_d = StIdle;
      StErr:      if (!out_full) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    in_rd_en  = (state_q == StRdReq) && !in_empty;
    eng_start = (state_q == StStart) ? eng_sel : '0;
    busy      = (state_q != StIdle);
    out_wr_en = 1'b0;
    out_data  = '0;
    if (state_q == StWr) begin
      out_wr_en = ser_wr_en;
      out_data  = ser_data;
    end else if (state_q == StErr) begin
      out_wr_en = !out_full;
      out_data  = {err_tag_q, {(DATA_W-8){1'b0}}, err_mode_q};
    end
    eng_a   = a_q;
    eng_b   = b_q;
    err_cnt = err_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= '0;
      mode_q     <= '0;
      have_a_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      timer_q    <= '0;
      err_tag_q  <= '0;
      err_mode_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == StRdSample) cmd_q <= in_data;
      if (state_q == StDecode) begin
        if (have_a_q) begin
          have_a_q <= 1'b0;
          if (cmd_mode == mode_q) begin
            b_q <= cmd_payload;
          end else begin
            err_tag_q  <= TAG_ERR_MISMATCH;
            err_mode_q <= cmd_mode;
          end
        end else if (mode_bad) begin
          err_tag_q  <= TAG_ERR_MODE;
          err_mode_q <= cmd_mode;
        end else begin
          mode_q   <= cmd_mode;
          a_q      <= cmd_payload;
          b_q      <= '0;
          have_a_q <= (mode_nops(cmd_mode) == 2'd2);
        end
      end
      if (state_q == StStart) begin
        timer_q <= '0;
      end else if (state_q == StWaitDone) begin
        timer_q <= timer_q + 1'b1;
        if (timed_out) begin
          err_tag_q  <= TAG_ERR_TIMEOUT;
          err_mode_q <= mode_q;
        end
      end
      if (state_q == StErr && !out_full && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  cordic_res_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     ((state_q == StWaitDone) && eng_hit),
    .nres     (mode_nres(mode_q)),
    .res      (res_sel),
    .tags     ({mode_tag(mode_q, 2'd2), mode_tag(mode_q, 2'd1), mode_tag(mode_q, 2'd0)}),
    .out_full (out_full),
    .wr_en    (ser_wr_en),
    .data     (ser_data),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_cordic_dispatch_ctrl.sv
// Directed bench for cordic_dispatch_ctrl with a small command FIFO model.
module tb_cordic_dispatch_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_ENG   = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned WORD_W  = DATA_W + 16;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [WORD_W-1:0]         in_data = '0;
  logic                      in_empty = 1'b1;
  logic                      in_rd_en;
  logic                      out_full = 1'b0;
  logic                      out_wr_en;
  logic [WORD_W-1:0]         out_data;
  logic [N_ENG-1:0]          eng_start;
  logic [DATA_W-1:0]         eng_a, eng_b;
  logic [N_ENG-1:0]          eng_done = '0;
  logic [N_ENG*3*DATA_W-1:0] eng_res = '0;
  logic                      busy;
  logic [7:0]                err_cnt;

  always #5 clk = ~clk;

  cordic_dispatch_ctrl #(
    .DATA_W  (DATA_W),
    .N_ENG   (N_ENG),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_data  (out_data),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_done  (eng_done),
    .eng_res   (eng_res),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int starts  = 0;
  int start_cyc = 0;
  int wr_full_viol = 0;
  int pop_empty = 0;
  int t0, s0, d;
  logic [N_ENG-1:0]  start_vec = '0;
  logic [DATA_W-1:0] start_a = '0, start_b = '0;
  logic [WORD_W-1:0] cmdq [$];
  logic [WORD_W-1:0] outq [$];
  int                out_cyc [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] cmd(input logic [7:0] mode, input logic [DATA_W-1:0] p);
    return {p, mode, 8'h00};
  endfunction

  task automatic push(input logic [WORD_W-1:0] w);
    cmdq.push_back(w);
    in_empty = 1'b0;
  endtask

  // Observe at the falling edge, update the FIFO model just after the rising edge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    cyc++;
    rd = in_rd_en;
    if (out_wr_en) begin
      if (out_full) wr_full_viol++;
      outq.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    if (eng_start != '0) begin
      starts++;
      start_cyc = cyc;
      start_vec = eng_start;
      start_a   = eng_a;
      start_b   = eng_b;
    end
    @(posedge clk);
    #1;
    if (rd) begin
      if (cmdq.size() != 0) in_data = cmdq.pop_front();
      else pop_empty++;
    end
    in_empty = (cmdq.size() == 0);
  endtask

  task automatic wait_start(input string tag);
    int s = starts;
    for (int i = 0; i < 50 && starts == s; i++) tick();
    check_eq(tag, 64'(starts - s), 64'd1);
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && outq.size() < n; i++) tick();
    check_eq(tag, 64'(outq.size()), 64'(n));
  endtask

  task automatic clear_out();
    outq.delete();
    out_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_start", 64'(eng_start), 64'd0);
    check_eq("rst_wr", 64'(out_wr_en), 64'd0);
    reset_n = 1'b1;
    tick();
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("rst_rd", 64'(in_rd_en), 64'd0);

    // Mode 1: single operand, two results after 20 cycles
    push(cmd(8'd1, 32'h0000_4000));
    t0 = cyc + 1;
    wait_start("m1_start");
    check_eq("m1_start_lat", 64'(start_cyc - t0), 64'd4);
    check_eq("m1_start_vec", 64'(start_vec), 64'h01);
    check_eq("m1_eng_a", 64'(start_a), 64'h4000);
    check_eq("m1_eng_b", 64'(start_b), 64'h0);
    repeat (19) tick();
    eng_res[0*DATA_W +: DATA_W] = 32'h11;
    eng_res[1*DATA_W +: DATA_W] = 32'h22;
    eng_done = 8'h01;
    d = cyc + 1;
    tick();
    eng_done = '0;
    wait_out("m1_nwords", 2, 10);
    if (outq.size() == 2) begin
      check_eq("m1_word0", 64'(outq[0]), 64'h000A_0000_0011);
      check_eq("m1_word1", 64'(outq[1]), 64'h000C_0000_0022);
      check_eq("m1_word0_lat", 64'(out_cyc[0] - d), 64'd1);
      check_eq("m1_word1_lat", 64'(out_cyc[1] - d), 64'd2);
    end
    tick();
    check_eq("m1_busy_drop", 64'(busy), 64'd0);
    check_eq("m1_err_cnt", 64'(err_cnt), 64'd0);
    clear_out();

    // Mode 8: two operands, stray done on another engine ignored
    s0 = starts;
    push(cmd(8'd8, 32'h100));
    push(cmd(8'd8, 32'h200));
    wait_start("m8_start");
    check_eq("m8_start_vec", 64'(start_vec), 64'h80);
    check_eq("m8_eng_a", 64'(start_a), 64'h100);
    check_eq("m8_eng_b", 64'(start_b), 64'h200);
    eng_done = 8'h01;
    tick();
    eng_done = '0;
    repeat (2) tick();
    check_eq("m8_stray_done", 64'(outq.size()), 64'd0);
    eng_res[(7*3+0)*DATA_W +: DATA_W] = 32'h55;
    eng_done = 8'h80;
    tick();
    eng_done = '0;
    wait_out("m8_nwords", 1, 10);
    if (outq.size() == 1) check_eq("m8_word", 64'(outq[0]), 64'h000B_0000_0055);
    check_eq("m8_one_start", 64'(starts - s0), 64'd1);
    repeat (2) tick();
    clear_out();

    // Mode 8 then mode 5: mismatch error, no start
    s0 = starts;
    push(cmd(8'd8, 32'h1));
    push(cmd(8'd5, 32'h2));
    wait_out("mm_nwords", 1, 30);
    if (outq.size() == 1) check_eq("mm_word", 64'(outq[0]), 64'h00ED_0000_0005);
    check_eq("mm_no_start", 64'(starts - s0), 64'd0);
    tick();
    check_eq("mm_err_cnt", 64'(err_cnt), 64'd1);
    clear_out();

    // Unknown mode 0x2A
    push(cmd(8'h2A, 32'h7));
    wait_out("bad_nwords", 1, 30);
    if (outq.size() == 1) check_eq("bad_word", 64'(outq[0]), 64'h00EE_0000_002A);
    tick();
    check_eq("bad_err_cnt", 64'(err_cnt), 64'd2);
    clear_out();

    // Mode 3 timeout, then a late done is ignored
    push(cmd(8'd3, 32'h9));
    wait_start("to_start");
    wait_out("to_nwords", 1, TIMEOUT + 10);
    if (outq.size() == 1) begin
      check_eq("to_word", 64'(outq[0]), 64'h00EF_0000_0003);
      check_eq("to_lat", 64'(out_cyc[0] - start_cyc), 64'(TIMEOUT + 1));
    end
    tick();
    check_eq("to_busy_drop", 64'(busy), 64'd0);
    check_eq("to_err_cnt", 64'(err_cnt), 64'd3);
    eng_done = 8'h04;
    tick();
    eng_done = '0;
    repeat (3) tick();
    check_eq("to_late_done", 64'(outq.size()), 64'd1);
    clear_out();

    // Mode 3 with result FIFO full for 5 cycles
    push(cmd(8'd3, 32'h0));
    wait_start("bp_start");
    repeat (2) tick();
    out_full = 1'b1;
    eng_res[(2*3+0)*DATA_W +: DATA_W] = 32'h1;
    eng_res[(2*3+1)*DATA_W +: DATA_W] = 32'h2;
    eng_res[(2*3+2)*DATA_W +: DATA_W] = 32'h3;
    eng_done = 8'h04;
    tick();
    eng_done = '0;
    repeat (4) tick();
    check_eq("bp_held", 64'(outq.size()), 64'd0);
    check_eq("bp_busy", 64'(busy), 64'd1);
    out_full = 1'b0;
    wait_out("bp_nwords", 3, 10);
    if (outq.size() == 3) begin
      check_eq("bp_word0", 64'(outq[0]), 64'h000A_0000_0001);
      check_eq("bp_word1", 64'(outq[1]), 64'h000C_0000_0002);
      check_eq("bp_word2", 64'(outq[2]), 64'h000B_0000_0003);
      check_eq("bp_b2b", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
    end
    repeat (2) tick();
    clear_out();

    // Reset during WAIT_DONE
    push(cmd(8'd1, 32'h5));
    wait_start("mr_start");
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_eng_a", 64'(eng_a), 64'd0);
    check_eq("mr_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("mr_out", 64'({out_wr_en, in_rd_en, eng_start, out_data}), 64'd0);
    tick();
    reset_n = 1'b1;
    eng_done = 8'h01;
    tick();
    eng_done = '0;
    repeat (4) tick();
    check_eq("mr_no_write", 64'(outq.size()), 64'd0);
    check_eq("mr_idle", 64'(busy), 64'd0);

    check_eq("no_wr_while_full", 64'(wr_full_viol), 64'd0);
    check_eq("no_pop_empty", 64'(pop_empty), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
